// File: rtl/icache_nway.sv
// N-way set-associative instruction cache with tree pseudo-LRU, flush, AXI4 burst refill.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_nway #(
    parameter int ADDR_WIDTH = 32,
    parameter int WAYS       = 4,
    parameter int SETS       = 64,
    parameter int LINE_BYTES = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic                  cpu_flush,
    output logic                  cpu_ready,
    output logic [31:0]           cpu_rdata,
    output logic                  cpu_err,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [7:0]            m_arlen,
    output logic [2:0]            m_arsize,
    output logic [1:0]            m_arburst,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    input  logic [31:0]           m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rlast,
    output logic [31:0]           stat_hits,
    output logic [31:0]           stat_misses
);
    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W;
    localparam int WORDS = LINE_BYTES / 4;
    localparam int WRD_W = $clog2(WORDS);
    localparam int WAY_W = $clog2(WAYS);

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_MISS_AR, S_MISS_R, S_RESP} state_e;

    state_e               state_q, state_d;
    logic [WAYS-1:0]      valid_q [SETS];
    logic [WAYS-2:0]      plru_q  [SETS];
    logic [TAG_W-1:0]     tag_q   [WAYS][SETS];
    logic [31:0]          data_q  [WAYS][SETS][WORDS];
    logic [31:0]          linebuf_q [WORDS];
    logic [WAY_W-1:0]     victim_q;
    logic [WRD_W-1:0]     cnt_q;
    logic                 err_q;

    logic [TAG_W-1:0]     req_tag;
    logic [IDX_W-1:0]     req_idx;
    logic [WRD_W-1:0]     req_wrd;
    logic                 hit;
    logic [WAY_W-1:0]     hit_way;
    logic                 inv_found;
    logic [WAY_W-1:0]     inv_way;
    logic [WAY_W-1:0]     victim;
    logic                 unused_addr_bits;

    assign req_tag          = cpu_addr[ADDR_WIDTH-1 -: TAG_W];
    assign req_idx          = cpu_addr[OFF_W +: IDX_W];
    assign req_wrd          = cpu_addr[2 +: WRD_W];
    assign unused_addr_bits = ^cpu_addr[1:0];

    // Tree walk: each node bit selects the subtree holding the next victim (0 = lower ways).
    function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] bits);
        int node;
        node = 0;
        for (int l = 0; l < WAY_W; l++) node = 2 * node + 1 + int'(bits[node]);
        return WAY_W'(node - (WAYS - 1));
    endfunction

    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                   input logic [WAY_W-1:0] way);
        logic [WAYS-2:0] r;
        logic            dir;
        int              node;
        r    = bits;
        node = 0;
        for (int l = 0; l < WAY_W; l++) begin
            dir     = way[WAY_W-1-l];
            r[node] = ~dir;
            node    = 2 * node + 1 + int'(dir);
        end
        return r;
    endfunction

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && tag_q[w][req_idx] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        // Descending scan so the lowest-index invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[req_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        victim = inv_found ? inv_way : plru_victim(plru_q[req_idx]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every output and state_d gets a default before the case, so no latch can be inferred.
    always_comb begin
        state_d   = state_q;
        cpu_ready = 1'b0;
        cpu_rdata = '0;
        cpu_err   = 1'b0;
        m_arvalid = 1'b0;
        m_araddr  = '0;
        m_arlen   = '0;
        m_arsize  = '0;
        m_arburst = '0;
        m_rready  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!cpu_flush && cpu_req) state_d = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (hit) begin
                    cpu_ready = 1'b1;
                    cpu_rdata = data_q[hit_way][req_idx][req_wrd];
                    state_d   = S_IDLE;
                end else begin
                    state_d = S_MISS_AR;
                end
            end
            S_MISS_AR: begin
                m_arvalid = 1'b1;
                m_araddr  = {cpu_addr[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
                m_arlen   = 8'(WORDS - 1);
                m_arsize  = 3'b010;
                m_arburst = 2'b01;
                if (m_arready) state_d = S_MISS_R;
            end
            S_MISS_R: begin
                m_rready = 1'b1;
                if (m_rvalid && m_rlast) state_d = S_RESP;
            end
            S_RESP: begin
                cpu_ready = 1'b1;
                cpu_rdata = linebuf_q[req_wrd];
                cpu_err   = err_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
            victim_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cpu_flush) for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
                end
                S_LOOKUP: begin
                    if (hit) plru_q[req_idx] <= plru_touch(plru_q[req_idx], hit_way);
                    else     victim_q        <= victim;
                end
                S_MISS_R: begin
                    if (m_rvalid) begin
                        cnt_q <= m_rlast ? '0 : cnt_q + WRD_W'(1);
                        if (m_rresp != 2'b00) err_q <= 1'b1;
                    end
                end
                S_RESP: begin
                    err_q <= 1'b0;
                    if (!err_q) begin
                        valid_q[req_idx][victim_q] <= 1'b1;
                        plru_q[req_idx]            <= plru_touch(plru_q[req_idx], victim_q);
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: tag, data and line-buffer arrays carry no reset; valid bits alone decide whether they are used.
    always_ff @(posedge clk) begin
        if (state_q == S_MISS_R && m_rvalid) linebuf_q[cnt_q] <= m_rdata;
        if (state_q == S_RESP && !err_q) begin
            tag_q[victim_q][req_idx] <= req_tag;
            for (int i = 0; i < WORDS; i++) data_q[victim_q][req_idx][i] <= linebuf_q[i];
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hits_q, misses_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else if (state_q == S_LOOKUP) begin
            if (hit) hits_q   <= hits_q + 32'd1;
            else     misses_q <= misses_q + 32'd1;
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
`else
    assign stat_hits   = '0;
    assign stat_misses = '0;
`endif

endmodule

// File: tb/tb_icache_nway.sv
// Directed bench for icache_nway: scoreboard of expected fetch results plus a behavioural AXI read slave.
module tb_icache_nway;
    localparam int WORDS = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic        cpu_flush = 1'b0;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic        cpu_err;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic        m_rvalid;
    logic        m_rready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rlast;
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;

    int          n_vec = 0;
    int          n_miss = 0;
    logic [32:0] sb_q [$];
    int          ar_count = 0;
    int          ar_delay = 0;
    int          err_beat = -1;
    int          beat_idx = -1;
    logic [31:0] exp_araddr = '0;
    logic [31:0] slv_addr;

    icache_nway dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_flush(cpu_flush),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
        .m_rresp(m_rresp), .m_rlast(m_rlast),
        .stat_hits(stat_hits), .stat_misses(stat_misses)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:5] == 27'h80) return 32'hA0 + {29'd0, a[4:2]};
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one fetch and checks data, error, latency and whether a refill burst happened.
    task automatic fetch(input logic [31:0] addr, input bit exp_hit, input bit exp_err,
                         input bit at_edge);
        int          cycles;
        int          ar0;
        logic [32:0] exp;
        if (!at_edge) @(negedge clk);
        exp_araddr = {addr[31:5], 5'd0};
        sb_q.push_back({exp_err, mem_word(addr)});
        ar0      = ar_count;
        cpu_req  = 1'b1;
        cpu_addr = addr;
        @(negedge clk);
        cycles = 1;
        while (!cpu_ready && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
        cpu_req = 1'b0;
        exp = sb_q.pop_front();
        if (!cpu_ready) begin
            check("cpu_ready_timeout", cpu_ready, 1);
        end else begin
            check("cpu_rdata", cpu_rdata, exp[31:0]);
            check("cpu_err", cpu_err, exp[32]);
            check("latency", cycles, exp_hit ? 1 : 3 + WORDS + ar_delay);
            check("refill_count", ar_count - ar0, exp_hit ? 0 : 1);
        end
    endtask

    // AXI read slave: checks the address phase, then returns one burst from mem_word().
    initial begin
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rdata   = '0;
        m_rresp   = '0;
        m_rlast   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && m_arvalid) begin
                slv_addr = m_araddr;
                ar_count++;
                check("araddr", m_araddr, exp_araddr);
                check("arlen", m_arlen, 7);
                check("arsize", m_arsize, 2);
                check("arburst", m_arburst, 1);
                for (int i = 0; i < ar_delay; i++) begin
                    @(negedge clk);
                    check("ar_hold", {m_arvalid, m_araddr}, {1'b1, slv_addr});
                end
                m_arready = 1'b1;
                @(negedge clk);
                m_arready = 1'b0;
                for (int b = 0; b < WORDS && rst_n; b++) begin
                    beat_idx = b;
                    m_rvalid = 1'b1;
                    m_rdata  = mem_word(slv_addr + 32'(4 * b));
                    m_rresp  = (b == err_beat) ? 2'b10 : 2'b00;
                    m_rlast  = (b == WORDS - 1);
                    @(negedge clk);
                end
                m_rvalid = 1'b0;
                m_rlast  = 1'b0;
                m_rresp  = 2'b00;
                beat_idx = -1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cycles;
        repeat (3) @(negedge clk);
        check("rst_cpu_ready", cpu_ready, 0);
        check("rst_arvalid", m_arvalid, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_outputs",
              {cpu_ready, cpu_err, cpu_rdata, m_arvalid, m_araddr, m_rready, m_arlen},
              '0);
        check("reset_stat_hits", stat_hits, 0);
        check("reset_stat_misses", stat_misses, 0);

        // Cold miss then hit on the same line.
        fetch(32'h0000_1004, 0, 0, 0);
        fetch(32'h0000_1004, 1, 0, 0);
        fetch(32'h0000_101C, 1, 0, 0);

        // Fill set 0, touch ways 0 and 2, a fifth tag must evict way 1 (0x0000).
        fetch(32'h0000_0000, 0, 0, 0);
        fetch(32'h0000_0800, 0, 0, 0);
        fetch(32'h0000_1800, 0, 0, 0);
        fetch(32'h0000_1000, 1, 0, 0);
        fetch(32'h0000_0800, 1, 0, 0);
        fetch(32'h0000_2000, 0, 0, 0);
        fetch(32'h0000_1000, 1, 0, 0);
        fetch(32'h0000_0804, 1, 0, 0);
        fetch(32'h0000_1808, 1, 0, 0);
        fetch(32'h0000_0000, 0, 0, 0);

        // Bus error on beat 3: reported, nothing installed.
        err_beat = 3;
        fetch(32'h0000_4028, 0, 1, 0);
        err_beat = -1;
        fetch(32'h0000_4028, 0, 0, 0);
        fetch(32'h0000_4028, 1, 0, 0);

        // Flush beats a simultaneous request, then everything misses.
        fetch(32'h0000_3040, 0, 0, 0);
        fetch(32'h0000_3060, 0, 0, 0);
        fetch(32'h0000_4028, 1, 0, 0);
        fetch(32'h0000_3044, 1, 0, 0);
        fetch(32'h0000_3060, 1, 0, 0);
        @(negedge clk);
        cpu_flush = 1'b1;
        cpu_req   = 1'b1;
        cpu_addr  = 32'h0000_3040;
        @(negedge clk);
        check("flush_wins", {cpu_ready, m_arvalid}, 0);
        cpu_flush = 1'b0;
        fetch(32'h0000_3040, 0, 0, 1);
        fetch(32'h0000_3060, 0, 0, 0);
        fetch(32'h0000_4028, 0, 0, 0);

        // AR backpressure: address held for five cycles.
        ar_delay = 5;
        fetch(32'h0000_5000, 0, 0, 0);
        ar_delay = 0;

        // Reset during the refill burst.
        @(negedge clk);
        exp_araddr = 32'h0000_6000;
        cpu_req    = 1'b1;
        cpu_addr   = 32'h0000_6004;
        cycles     = 0;
        while (beat_idx != 4 && cycles < 200) begin
            @(posedge clk);
            cycles++;
        end
        #2;
        check("beat4_reached", beat_idx, 4);
        check("rready_before_rst", m_rready, 1);
        rst_n = 1'b0;
        #1;
        check("rready_in_rst", m_rready, 0);
        check("arvalid_in_rst", m_arvalid, 0);
        check("ready_in_rst", cpu_ready, 0);
        cpu_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_stat_hits", stat_hits, 0);
        check("post_rst_stat_misses", stat_misses, 0);

        // Line was not installed; then 3 misses and 5 hits for the counters.
        fetch(32'h0000_6004, 0, 0, 0);
        fetch(32'h0000_7000, 0, 0, 0);
        fetch(32'h0000_7020, 0, 0, 0);
        fetch(32'h0000_6004, 1, 0, 0);
        fetch(32'h0000_7000, 1, 0, 0);
        fetch(32'h0000_7020, 1, 0, 0);
        fetch(32'h0000_7004, 1, 0, 0);
        fetch(32'h0000_6008, 1, 0, 0);
        @(negedge clk);
`ifdef ICACHE_STATS_EN
        check("stat_hits", stat_hits, 5);
        check("stat_misses", stat_misses, 3);
`else
        check("stat_hits", stat_hits, 0);
        check("stat_misses", stat_misses, 0);
`endif
        check("scoreboard_empty", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
